la_strapcap: RTL and testbench

Strap-capture stage that consumes tie-cell and pad-strap levels (la_tiehi/la_tielo outputs, board straps) and turns them into a registered, qualified configuration word. After reset it waits a settle window, then requires a run of identical samples before latching `cfg` and asserting `valid`. It sits between constant/strap sources and the configuration consumers (clock muxes, boot selects), so downstream logic never sees raw or glitching strap levels.

---
 rtl/la_strapcap_pkg.sv | 17 +
 rtl/la_strapcap_if.sv | 23 ++
 rtl/la_dsync.sv | 47 ++++
 rtl/la_strapcap.sv | 148 ++++++++++++++
 tb/tb_la_strapcap.sv | 251 +++++++++++++++++++++++++
 5 files changed

// File: rtl/la_strapcap_pkg.sv
// Shared definitions for the strap-capture block: FSM state encoding and
// the helper that sizes the saturating counters.
package la_strapcap_pkg;

  // 2'd3 is never entered; the FSM treats it as SETTLE.
  typedef enum logic [1:0] {
    ST_SETTLE = 2'd0,
    ST_SAMPLE = 2'd1,
    ST_DONE   = 2'd2
  } state_e;

  // Bits needed to hold a count from 0 up to and including x.
  function automatic int unsigned cnt_w(input int unsigned x);
    return 32'($clog2(x + 1));
  endfunction

endpackage

// File: rtl/la_strapcap_if.sv
// Strap-capture bus: raw strap levels and rearm request in, qualified
// configuration word and status out.
//   strap : raw strap levels (async to clk)
//   rearm : single-cycle re-capture request
//   cfg   : captured configuration
//   valid : cfg is qualified
//   busy  : capture in progress
//   err   : last capture was forced by the retry limit
interface la_strapcap_if #(
  parameter int unsigned N = 8
);
  logic [N-1:0] strap;
  logic         rearm;
  logic [N-1:0] cfg;
  logic         valid;
  logic         busy;
  logic         err;

  // Strap/config source and consumer side.
  modport master (output strap, rearm, input cfg, valid, busy, err);
  // Capture block side.
  modport slave  (input strap, rearm, output cfg, valid, busy, err);
endinterface

// File: rtl/la_dsync.sv
// Two-flop level synchronizer, N bits wide, flops reset to 0.
//   clk    : destination clock
//   nreset : asynchronous active-low reset
//   in_i   : asynchronous input levels
//   out_o  : synchronized levels
module la_dsync #(
  parameter int unsigned N    = 1,
  parameter string       PROP = "DEFAULT"
) (
  input  logic         clk,
  input  logic         nreset,
  input  logic [N-1:0] in_i,
  output logic [N-1:0] out_o
);

  logic [N-1:0] meta_q;
  logic [N-1:0] sync_q;

  // Non-default PROP values map to a hardened synchronizer cell in the
  // implementation flow; behaviourally both are the same two-flop chain.
  generate
    if (PROP == "DEFAULT") begin : g_generic
      always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
          meta_q <= '0;
          sync_q <= '0;
        end else begin
          meta_q <= in_i;
          sync_q <= meta_q;
        end
      end
    end else begin : g_cell
      always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
          meta_q <= '0;
          sync_q <= '0;
        end else begin
          meta_q <= in_i;
          sync_q <= meta_q;
        end
      end
    end
  endgenerate

  assign out_o = sync_q;

endmodule

// File: rtl/la_strapcap.sv
// Strap capture: synchronizes raw strap levels, waits a settle window after
// reset/rearm, then requires SAMPLES identical samples (or gives up after
// MAXRETRY mismatches) before presenting a registered, qualified cfg word.
//   clk    : clock
//   nreset : asynchronous active-low reset
//   bus    : la_strapcap_if slave (strap, rearm in; cfg, valid, busy, err out)
module la_strapcap
  import la_strapcap_pkg::*;
#(
  parameter int unsigned N        = 8,
  parameter int unsigned SETTLE   = 16,
  parameter int unsigned SAMPLES  = 4,
  parameter int unsigned MAXRETRY = 15,
  parameter string       PROP     = "DEFAULT"
) (
  input  logic           clk,
  input  logic           nreset,
  la_strapcap_if.slave   bus
);

  localparam int unsigned SET_W = cnt_w(SETTLE);
  localparam int unsigned SMP_W = cnt_w(SAMPLES);
  localparam int unsigned RTY_W = cnt_w(MAXRETRY);

  logic [N-1:0] s;

  state_e             state_q,  state_d;
  logic [SET_W-1:0]   settle_q, settle_d;
  logic [SMP_W-1:0]   stable_q, stable_d;
  logic [RTY_W-1:0]   retry_q,  retry_d;
  logic [N-1:0]       ref_q,    ref_d;
  logic [N-1:0]       cfg_q,    cfg_d;
  logic               valid_q,  valid_d;
  logic               busy_q,   busy_d;
  logic               err_q,    err_d;

  // Strap synchronizer; everything downstream sees only s.
  la_dsync #(
    .N    (N),
    .PROP (PROP)
  ) u_dsync (
    .clk    (clk),
    .nreset (nreset),
    .in_i   (bus.strap),
    .out_o  (s)
  );

  // Next-state and output logic.
  always_comb begin
    state_d  = state_q;
    settle_d = settle_q;
    stable_d = stable_q;
    retry_d  = retry_q;
    ref_d    = ref_q;
    cfg_d    = cfg_q;
    valid_d  = valid_q;
    err_d    = err_q;

    case (state_q)
      ST_SETTLE: begin
        if (settle_q == SET_W'(SETTLE - 1)) begin
          state_d  = ST_SAMPLE;
          settle_d = '0;
          stable_d = '0;
          retry_d  = '0;
        end else begin
          settle_d = settle_q + SET_W'(1);
        end
      end

      ST_SAMPLE: begin
        if (stable_q == SMP_W'(0)) begin
          ref_d    = s;
          stable_d = SMP_W'(1);
        end else if (s == ref_q) begin
          if (stable_q != SMP_W'(SAMPLES)) stable_d = stable_q + SMP_W'(1);
        end else begin
          ref_d    = s;
          stable_d = SMP_W'(1);
          if (retry_q != RTY_W'(MAXRETRY)) retry_d = retry_q + RTY_W'(1);
        end

        // A clean run takes priority over the retry limit on the same edge.
        if (stable_d == SMP_W'(SAMPLES)) begin
          cfg_d   = ref_d;
          valid_d = 1'b1;
          err_d   = 1'b0;
          state_d = ST_DONE;
        end else if (retry_d == RTY_W'(MAXRETRY)) begin
          cfg_d   = s;
          valid_d = 1'b1;
          err_d   = 1'b1;
          state_d = ST_DONE;
        end
      end

      ST_DONE: begin
        if (bus.rearm) begin
          state_d  = ST_SETTLE;
          valid_d  = 1'b0;
          settle_d = '0;
          stable_d = '0;
          retry_d  = '0;
        end
      end

      default: begin
        state_d  = ST_SETTLE;
        settle_d = '0;
        stable_d = '0;
        retry_d  = '0;
      end
    endcase

    busy_d = (state_d != ST_DONE);
  end

  // State and output registers.
  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      state_q  <= ST_SETTLE;
      settle_q <= '0;
      stable_q <= '0;
      retry_q  <= '0;
      ref_q    <= '0;
      cfg_q    <= '0;
      valid_q  <= 1'b0;
      busy_q   <= 1'b1;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      settle_q <= settle_d;
      stable_q <= stable_d;
      retry_q  <= retry_d;
      ref_q    <= ref_d;
      cfg_q    <= cfg_d;
      valid_q  <= valid_d;
      busy_q   <= busy_d;
      err_q    <= err_d;
    end
  end

  assign bus.cfg   = cfg_q;
  assign bus.valid = valid_q;
  assign bus.busy  = busy_q;
  assign bus.err   = err_q;

endmodule

// File: tb/tb_la_strapcap.sv
// Bench for la_strapcap: directed scenarios plus randomized strap/rearm
// traffic, checked against a cycle-level behavioural model and a capture
// scoreboard.
module tb_la_strapcap;

  localparam int unsigned N        = 8;
  localparam int unsigned SETTLE   = 16;
  localparam int unsigned SAMPLES  = 4;
  localparam int unsigned MAXRETRY = 15;

  typedef struct {
    logic [N-1:0] cfg;
    logic         err;
    int           edge_n;
  } cap_t;

  logic clk    = 1'b0;
  logic nreset = 1'b0;

  la_strapcap_if #(.N(N)) bus ();

  la_strapcap #(
    .N        (N),
    .SETTLE   (SETTLE),
    .SAMPLES  (SAMPLES),
    .MAXRETRY (MAXRETRY),
    .PROP     ("DEFAULT")
  ) u_dut (
    .clk    (clk),
    .nreset (nreset),
    .bus    (bus.slave)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h t=%0t", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural reference model ----------------
  // Tracks edges since the last arm, the length of the current identical
  // run and the number of mismatches, following the capture rules directly.
  cap_t         sb[$];
  logic [N-1:0] m_pipe[$];
  int           m_rel_edge;
  int           m_since_arm;
  int           m_run;
  int           m_miss;
  logic [N-1:0] m_ref;
  bit           m_done;
  logic         m_valid;
  logic [N-1:0] m_cfg;
  logic         m_err;

  task automatic m_capture(input logic [N-1:0] c, input logic e);
    cap_t x;
    m_done  = 1'b1;
    m_valid = 1'b1;
    m_cfg   = c;
    m_err   = e;
    x.cfg    = c;
    x.err    = e;
    x.edge_n = m_rel_edge;
    sb.push_back(x);
  endtask

  always @(posedge clk or negedge nreset) begin
    logic [N-1:0] s;
    if (!nreset) begin
      m_pipe      = '{'0, '0};
      m_rel_edge  = 0;
      m_since_arm = 0;
      m_run       = 0;
      m_miss      = 0;
      m_ref       = '0;
      m_done      = 1'b0;
      m_valid     = 1'b0;
      m_cfg       = '0;
      m_err       = 1'b0;
      sb.delete();
    end else begin
      m_rel_edge++;
      // The value compared on this edge is the strap level two edges ago.
      s = m_pipe.pop_front();
      m_pipe.push_back(bus.strap);
      if (m_done) begin
        if (bus.rearm) begin
          m_done      = 1'b0;
          m_valid     = 1'b0;
          m_since_arm = 0;
        end
      end else if (m_since_arm < SETTLE) begin
        m_since_arm++;
        m_run  = 0;
        m_miss = 0;
      end else begin
        if (m_run == 0) begin
          m_ref = s;
          m_run = 1;
        end else if (s == m_ref) begin
          m_run++;
        end else begin
          m_ref = s;
          m_run = 1;
          m_miss++;
        end
        if (m_run >= SAMPLES)       m_capture(m_ref, 1'b0);
        else if (m_miss >= MAXRETRY) m_capture(s, 1'b1);
      end
    end
  end

  // ---------------- monitor ----------------
  logic prev_valid = 1'b0;

  always @(negedge clk) begin
    cap_t e;
    if (nreset) begin
      check("outputs_vs_model",
            64'({bus.valid, bus.busy, bus.err, bus.cfg}),
            64'({m_valid, ~m_done, m_err, m_cfg}));
      if (bus.valid && !prev_valid) begin
        if (sb.size() == 0) begin
          check("sb_unexpected_capture", 64'(1), 64'(0));
        end else begin
          e = sb.pop_front();
          check("sb_cfg",  64'(bus.cfg), 64'(e.cfg));
          check("sb_err",  64'(bus.err), 64'(e.err));
          check("sb_edge", 64'(m_rel_edge), 64'(e.edge_n));
        end
      end
      prev_valid = bus.valid;
    end else begin
      prev_valid = 1'b0;
    end
  end

  // ---------------- stimulus ----------------
  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic pulse_rearm();
    bus.rearm = 1'b1;
    cyc(1);
    bus.rearm = 1'b0;
  endtask

  initial begin
    bus.strap = 8'hA5;
    bus.rearm = 1'b0;
    nreset    = 1'b0;
    cyc(2);
    check("reset_state", 64'({bus.valid, bus.busy, bus.err, bus.cfg}), 64'({1'b0, 1'b1, 1'b0, 8'h00}));
    nreset = 1'b1;

    // Static strap: capture on edge 20.
    cyc(19);
    check("static_pre_valid", 64'({bus.valid, bus.busy}), 64'({1'b0, 1'b1}));
    cyc(1);
    check("static_valid", 64'({bus.valid, bus.busy, bus.err, bus.cfg}), 64'({1'b1, 1'b0, 1'b0, 8'hA5}));
    cyc(3);

    // Rearm with a new strap value: cfg holds until re-capture.
    bus.strap = 8'h3C;
    cyc(3);
    pulse_rearm();
    check("rearm_valid_fall", 64'({bus.valid, bus.cfg}), 64'({1'b0, 8'hA5}));
    cyc(19);
    check("rearm_cfg_hold", 64'({bus.valid, bus.cfg}), 64'({1'b0, 8'hA5}));
    cyc(1);
    check("rearm_recapture", 64'({bus.valid, bus.err, bus.cfg}), 64'({1'b1, 1'b0, 8'h3C}));

    // One-cycle glitch on bit 0 mid-SAMPLE delays capture by two edges.
    bus.strap = 8'hA5;
    cyc(3);
    pulse_rearm();
    cyc(15);
    bus.strap = 8'hA4;
    cyc(1);
    bus.strap = 8'hA5;
    cyc(5);
    check("glitch_delayed", 64'(bus.valid), 64'(0));
    cyc(1);
    check("glitch_capture", 64'({bus.valid, bus.err, bus.cfg}), 64'({1'b1, 1'b0, 8'hA5}));

    // Toggling strap: forced capture after 15 mismatches.
    pulse_rearm();
    for (int i = 1; i <= 40; i++) begin
      cyc(1);
      if (i == 31) check("toggle_pre_force", 64'(bus.valid), 64'(0));
      if (i == 32) check("toggle_forced", 64'({bus.valid, bus.err, bus.cfg}), 64'({1'b1, 1'b1, 8'hFF}));
      bus.strap = (i % 2 == 1) ? 8'hFF : 8'h00;
    end

    // Rearm during SETTLE is ignored.
    bus.strap = 8'h5A;
    cyc(3);
    pulse_rearm();
    cyc(4);
    pulse_rearm();
    cyc(14);
    check("settle_rearm_pre", 64'(bus.valid), 64'(0));
    cyc(1);
    check("settle_rearm_cap", 64'({bus.valid, bus.err, bus.cfg}), 64'({1'b1, 1'b0, 8'h5A}));

    // Reset mid-SAMPLE clears everything immediately.
    pulse_rearm();
    cyc(18);
    #2 nreset = 1'b0;
    #1 check("reset_mid_sample", 64'({bus.valid, bus.busy, bus.err, bus.cfg}), 64'({1'b0, 1'b1, 1'b0, 8'h00}));
    cyc(2);
    nreset = 1'b1;
    cyc(19);
    check("post_reset_pre", 64'({bus.valid, bus.busy}), 64'({1'b0, 1'b1}));
    cyc(1);
    check("post_reset_cap", 64'({bus.valid, bus.busy, bus.err, bus.cfg}), 64'({1'b1, 1'b0, 1'b0, 8'h5A}));

    // Randomized strap flips and rearm pulses.
    for (int r = 0; r < 8; r++) begin
      bus.strap = 8'($urandom);
      cyc(2);
      pulse_rearm();
      for (int c = 0; c < 30; c++) begin
        cyc(1);
        if ($urandom_range(0, 5) == 0) bus.strap = bus.strap ^ 8'(1 << $urandom_range(0, 7));
        bus.rearm = ($urandom_range(0, 19) == 0);
      end
      bus.rearm = 1'b0;
    end
    cyc(80);
    check("sb_drained", 64'(sb.size()), 64'(0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1);
  end

endmodule
